// File: rtl/rat_maze_engine.sv
// Depth-first maze solver over a 2^CW x 2^CW one-bit-per-cell RAM (1 = wall or visited).
// After reaching the far corner it streams the solved path, start first, over valid/ready.
module rat_maze_engine #(
    parameter int CW        = 4,
    parameter int STK_DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [2*CW-1:0] mem_addr,
    output logic            mem_rd,
    input  logic            mem_rdata,
    output logic            mem_wr,
    output logic            mem_wdata,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic            overflow,
    output logic [15:0]     step_count,
    output logic            path_valid,
    input  logic            path_ready,
    output logic [2*CW-1:0] path_loc,
    output logic            path_last
);

    localparam int AW  = 2 * CW;
    localparam int SAW = $clog2(STK_DEPTH);
    localparam logic [AW-1:0] DEST    = '1;
    localparam logic [SAW:0]  SP_ONE  = (SAW + 1)'(1);
    localparam logic [SAW:0]  SP_FULL = (SAW + 1)'(STK_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_MARK, S_CHECK, S_EVAL, S_NEXT,
        S_BACK, S_PUSHD, S_PATH, S_DONE, S_FAIL
    } state_t;

    state_t         state;
    logic [AW-1:0]  cur;
    logic [1:0]     dir;
    logic [SAW:0]   sp;
    logic [SAW:0]   rd_ptr;
    logic [AW-1:0]  stack [STK_DEPTH];

    // Returns {in_range, neighbour location} for a cell and a direction.
    function automatic logic [AW:0] neighbour(input logic [AW-1:0] loc, input logic [1:0] d);
        logic [CW-1:0] y;
        logic [CW-1:0] x;
        logic          ok;
        y  = loc[AW-1:CW];
        x  = loc[CW-1:0];
        ok = 1'b0;
        case (d)
            2'd0: begin ok = (y != '1); y = y + CW'(1); end
            2'd1: begin ok = (x != '1); x = x + CW'(1); end
            2'd2: begin ok = (x != '0); x = x - CW'(1); end
            default: begin ok = (y != '0); y = y - CW'(1); end
        endcase
        return {ok, y, x};
    endfunction

    logic [AW:0]   nb_info;
    logic [AW:0]   chk_first;
    logic [AW:0]   chk_next;
    logic [AW:0]   chk_back;
    logic [SAW:0]  sp_m1;
    logic [SAW:0]  rd_nxt;
    logic [AW-1:0] pop_loc;

    assign sp_m1     = sp - SP_ONE;
    assign rd_nxt    = rd_ptr + SP_ONE;
    assign pop_loc   = stack[sp_m1[SAW-1:0]];
    assign nb_info   = neighbour(cur, dir);
    assign chk_first = neighbour(cur, 2'd0);
    assign chk_next  = neighbour(cur, dir + 2'd1);
    assign chk_back  = neighbour(pop_loc, 2'd0);

    // NOTE: outputs are registered, so each one is loaded on the transition into the state
    // that owns it; the strobes are cleared by default every cycle so they last one state.
    // NOTE: the path stack is intentionally left out of reset; sp alone says which entries are live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cur        <= '0;
            dir        <= '0;
            sp         <= '0;
            rd_ptr     <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            overflow   <= 1'b0;
            step_count <= '0;
            path_valid <= 1'b0;
            path_loc   <= '0;
            path_last  <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        cur        <= '0;
                        sp         <= '0;
                        dir        <= '0;
                        step_count <= '0;
                        overflow   <= 1'b0;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        busy       <= 1'b1;
                        mem_wr     <= 1'b1;
                        mem_wdata  <= 1'b1;
                        mem_addr   <= '0;
                        state      <= S_MARK;
                    end
                end
                S_MARK: begin
                    if (cur == DEST) begin
                        state <= S_PUSHD;
                    end else begin
                        dir      <= 2'd0;
                        mem_rd   <= chk_first[AW];
                        mem_addr <= chk_first[AW-1:0];
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: state <= nb_info[AW] ? S_EVAL : S_NEXT;
                S_EVAL: begin
                    if (mem_rdata) begin
                        state <= S_NEXT;
                    end else if (sp == SP_FULL) begin
                        overflow <= 1'b1;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_FAIL;
                    end else begin
                        stack[sp[SAW-1:0]] <= cur;
                        sp        <= sp + SP_ONE;
                        cur       <= nb_info[AW-1:0];
                        if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
                        mem_wr    <= 1'b1;
                        mem_wdata <= 1'b1;
                        mem_addr  <= nb_info[AW-1:0];
                        state     <= S_MARK;
                    end
                end
                S_NEXT: begin
                    if (dir == 2'd3) begin
                        state <= S_BACK;
                    end else begin
                        dir      <= dir + 2'd1;
                        mem_rd   <= chk_next[AW];
                        mem_addr <= chk_next[AW-1:0];
                        state    <= S_CHECK;
                    end
                end
                S_BACK: begin
                    if (sp == '0) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FAIL;
                    end else begin
                        cur      <= pop_loc;
                        sp       <= sp_m1;
                        dir      <= 2'd0;
                        mem_rd   <= chk_back[AW];
                        mem_addr <= chk_back[AW-1:0];
                        state    <= S_CHECK;
                    end
                end
                S_PUSHD: begin
                    if (sp == SP_FULL) begin
                        overflow <= 1'b1;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_FAIL;
                    end else begin
                        stack[sp[SAW-1:0]] <= cur;
                        sp         <= sp + SP_ONE;
                        rd_ptr     <= '0;
                        path_valid <= 1'b1;
                        path_loc   <= (sp == '0) ? cur : stack[0];
                        path_last  <= (sp == '0);
                        state      <= S_PATH;
                    end
                end
                S_PATH: begin
                    if (path_ready) begin
                        if (path_last) begin
                            path_valid <= 1'b0;
                            path_last  <= 1'b0;
                            path_loc   <= '0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            rd_ptr    <= rd_nxt;
                            path_loc  <= stack[rd_nxt[SAW-1:0]];
                            path_last <= (rd_nxt == sp_m1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rat_maze_engine.sv
// Self-checking bench for rat_maze_engine: directed mazes plus random mazes scored
// against a plain depth-first search model with per-step cycle costs.
module tb_rat_maze_engine;

    localparam int CW      = 2;
    localparam int S       = 1 << CW;
    localparam int N       = S * S;
    localparam int AW      = 2 * CW;
    localparam int DEPTH_A = 16;
    localparam int DEPTH_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          start_a, mem_rd_a, mem_wr_a, mem_wdata_a, busy_a, done_a, fail_a, ovf_a;
    logic          path_valid_a, path_ready_a, path_last_a;
    logic          mem_rdata_a = 1'b0;
    logic [AW-1:0] mem_addr_a, path_loc_a;
    logic [15:0]   step_a;

    logic          start_b, mem_rd_b, mem_wr_b, mem_wdata_b, busy_b, done_b, fail_b, ovf_b;
    logic          path_valid_b, path_ready_b, path_last_b;
    logic          mem_rdata_b = 1'b0;
    logic [AW-1:0] mem_addr_b, path_loc_b;
    logic [15:0]   step_b;

    rat_maze_engine #(.CW(CW), .STK_DEPTH(DEPTH_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_rdata(mem_rdata_a),
        .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a),
        .busy(busy_a), .done(done_a), .fail(fail_a), .overflow(ovf_a), .step_count(step_a),
        .path_valid(path_valid_a), .path_ready(path_ready_a), .path_loc(path_loc_a), .path_last(path_last_a)
    );

    rat_maze_engine #(.CW(CW), .STK_DEPTH(DEPTH_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b),
        .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b),
        .busy(busy_b), .done(done_b), .fail(fail_b), .overflow(ovf_b), .step_count(step_b),
        .path_valid(path_valid_b), .path_ready(path_ready_b), .path_loc(path_loc_b), .path_last(path_last_b)
    );

    // Maze RAMs: one-cycle read latency, write at the strobe edge, bulk load from the bench.
    logic [N-1:0] ram_a, ram_b, load_val_a, load_val_b;
    logic         load_a = 1'b0, load_b = 1'b0;
    int           wr_cnt_a = 0, wr_cnt_b = 0, wdata_err = 0;

    always @(posedge clk) begin
        if (load_a) begin
            ram_a    <= load_val_a;
            wr_cnt_a <= 0;
        end else begin
            if (mem_rd_a) mem_rdata_a <= ram_a[mem_addr_a];
            if (mem_wr_a) begin
                ram_a[mem_addr_a] <= mem_wdata_a;
                wr_cnt_a <= wr_cnt_a + 1;
                if (mem_wdata_a !== 1'b1) wdata_err <= wdata_err + 1;
            end
        end
        if (load_b) begin
            ram_b    <= load_val_b;
            wr_cnt_b <= 0;
        end else begin
            if (mem_rd_b) mem_rdata_b <= ram_b[mem_addr_b];
            if (mem_wr_b) begin
                ram_b[mem_addr_b] <= mem_wdata_b;
                wr_cnt_b <= wr_cnt_b + 1;
            end
        end
    end

    // Stream and busy monitor, sampled on the falling edge.
    logic          mon_clr = 1'b1;
    int            busy_cyc, busy_cyc_b, stab_err;
    int            got_loc[$];
    int            got_last[$];
    logic          prev_stall;
    logic [AW-1:0] prev_loc;
    logic          prev_last;

    always @(negedge clk) begin
        if (mon_clr) begin
            busy_cyc = 0; busy_cyc_b = 0; stab_err = 0; prev_stall = 1'b0;
            got_loc.delete(); got_last.delete();
        end else begin
            if (busy_a) busy_cyc++;
            if (busy_b) busy_cyc_b++;
            if (prev_stall && !(path_valid_a && path_loc_a == prev_loc && path_last_a == prev_last))
                stab_err++;
            if (path_valid_a && path_ready_a) begin
                got_loc.push_back(int'(path_loc_a));
                got_last.push_back(int'(path_last_a));
            end
            prev_stall = path_valid_a && !path_ready_a;
            prev_loc   = path_loc_a;
            prev_last  = path_last_a;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: iterative depth-first search with an explicit stack.
    int           exp_path[$];
    bit           exp_fail, exp_ovf;
    int           exp_steps, exp_wr, exp_cyc;
    logic [N-1:0] exp_ram;

    function automatic int nb_of(input int loc, input int d);
        int y = loc / S;
        int x = loc % S;
        case (d)
            0: y++;
            1: x++;
            2: x--;
            default: y--;
        endcase
        if (x < 0 || x >= S || y < 0 || y >= S) return -1;
        return y * S + x;
    endfunction

    function automatic void model(input logic [N-1:0] maze, input int depth);
        int stk[$];
        int cur = 0;
        int nxt;
        int nb;
        bit need_mark = 1'b1;
        exp_ram = maze; exp_fail = 0; exp_ovf = 0;
        exp_steps = 0; exp_wr = 0; exp_cyc = 0;
        exp_path.delete();
        for (int guard = 0; guard < 10000; guard++) begin
            if (need_mark) begin
                exp_ram[cur] = 1'b1;
                exp_wr++;
                exp_cyc++;
                if (cur == N - 1) begin
                    exp_cyc++;
                    if (stk.size() == depth) begin
                        exp_fail = 1; exp_ovf = 1;
                    end else begin
                        stk.push_back(cur);
                        exp_path = stk;
                        exp_cyc += stk.size();
                    end
                    break;
                end
            end
            nxt = -1;
            for (int d = 0; d < 4; d++) begin
                nb = nb_of(cur, d);
                if (nb < 0) exp_cyc += 2;
                else if (exp_ram[nb]) exp_cyc += 3;
                else begin
                    exp_cyc += 2;
                    nxt = nb;
                    break;
                end
            end
            if (nxt >= 0) begin
                if (stk.size() == depth) begin
                    exp_fail = 1; exp_ovf = 1;
                    break;
                end
                stk.push_back(cur);
                cur = nxt;
                exp_steps++;
                need_mark = 1'b1;
            end else begin
                exp_cyc++;
                if (stk.size() == 0) begin
                    exp_fail = 1;
                    break;
                end
                cur = stk.pop_back();
                need_mark = 1'b0;
            end
        end
    endfunction

    function automatic logic [63:0] packed_path();
        logic [63:0] v = '0;
        foreach (got_loc[i]) v = {v[59:0], 4'(got_loc[i])};
        return v;
    endfunction

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic load_ram_a(input logic [N-1:0] val);
        load_val_a = val;
        load_a = 1'b1;
        @(posedge clk);
        #1 load_a = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".a_outs"}, {busy_a, done_a, fail_a, ovf_a, mem_rd_a, mem_wr_a, mem_wdata_a,
                                 path_valid_a, path_last_a, mem_addr_a, path_loc_a, step_a}, 64'd0);
        check({tag, ".b_outs"}, {busy_b, done_b, fail_b, ovf_b, mem_rd_b, mem_wr_b, mem_wdata_b,
                                 path_valid_b, path_last_b, mem_addr_b, path_loc_b, step_b}, 64'd0);
    endtask

    // mode: 0 = ready held high, 1 = ready toggles every cycle, 2 = random ready.
    task automatic run_a(input logic [N-1:0] maze, input int mode, input string tag);
        int n = 0;
        model(maze, DEPTH_A);
        load_ram_a(maze);
        clear_mon();
        path_ready_a = (mode == 0) ? 1'b1 : 1'b0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        while (!(done_a || fail_a) && n < 3000) begin
            case (mode)
                0: path_ready_a = 1'b1;
                1: path_ready_a = ~path_ready_a;
                default: path_ready_a = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".timeout"}, n < 3000, 1);
        check({tag, ".done"}, done_a, !exp_fail);
        check({tag, ".fail"}, fail_a, exp_fail);
        check({tag, ".overflow"}, ovf_a, exp_ovf);
        check({tag, ".steps"}, step_a, exp_steps);
        check({tag, ".writes"}, wr_cnt_a, exp_wr);
        check({tag, ".ram"}, ram_a, exp_ram);
        check({tag, ".idle"}, {busy_a, path_valid_a}, 2'b00);
        check({tag, ".beats"}, got_loc.size(), exp_path.size());
        for (int i = 0; i < exp_path.size() && i < got_loc.size(); i++)
            check($sformatf("%s.loc%0d", tag, i), got_loc[i], exp_path[i]);
        if (!exp_fail && got_last.size() > 0)
            check({tag, ".last"}, {got_last.sum(), got_last[got_last.size() - 1]}, {32'd1, 32'd1});
        check({tag, ".stable"}, stab_err, 0);
        if (mode == 0) check({tag, ".cycles"}, busy_cyc, exp_cyc);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        path_ready_a = 1'b1; path_ready_b = 1'b1;
        load_val_a = '0; load_val_b = '0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b1;

        run_a(16'h0000, 0, "free");
        check("free.seq", packed_path(), 64'h048CDEF);
        run_a(16'h0012, 0, "boxed");
        run_a(16'h28EE, 0, "detour");
        check("detour.seq", packed_path(), 64'h0489AEF);
        run_a(16'h0000, 1, "bp");
        check("bp.seq", packed_path(), 64'h048CDEF);

        // Shallow stack: the fifth push attempt overflows.
        model(16'h0000, DEPTH_B);
        load_val_b = '0; load_b = 1'b1;
        @(posedge clk); #1 load_b = 1'b0;
        clear_mon();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        n = 0;
        while (!(done_b || fail_b) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("small.timeout", n < 1000, 1);
        check("small.flags", {done_b, fail_b, ovf_b}, 3'b011);
        check("small.writes", wr_cnt_b, 5);
        check("small.steps", step_b, exp_steps);
        check("small.cycles", busy_cyc_b, exp_cyc);

        // Reset in the middle of the stream, then repeat the free-maze solve.
        load_ram_a(16'h0000);
        path_ready_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        n = 0;
        while (!path_valid_a && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid.reach_path", n < 500, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("mid_rst");
        rst = 1'b1;
        run_a(16'h0000, 0, "after_rst");
        check("after_rst.seq", packed_path(), 64'h048CDEF);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] maze;
            maze = N'($urandom & $urandom);
            run_a(maze, int'($urandom_range(0, 2)), $sformatf("rand%0d", t));
        end

        check("wdata_one", wdata_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rat_maze_engine.md
# rat_maze_engine

Parametrised depth-first maze solver. It generalises the fixed 16x16 rat-in-maze controller to a 2^CW x 2^CW maze. The location register, direction counter and path stack are internal, and it can overflow-check the stack. After success it streams the solved path out over a valid/ready handshake. It sits between the top-level start/status logic and a 1-bit-per-cell maze RAM, where 1 means wall or visited and 0 means free.

## Interface
- CW, default 4: coordinate width; maze side = 2^CW; location = {y,x}, 2*CW bits.
- STK_DEPTH, default 256: path stack entries; SAW = clog2(STK_DEPTH).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset. Sampled on the clk edge; 0 resets.
- start  in  1  one-cycle pulse; begins a solve. Accepted only in IDLE, DONE or FAIL.
- mem_addr  out  2*CW  cell address {y,x}.
- mem_rd  out  1  read strobe; mem_rdata is valid exactly one cycle later.
- mem_rdata  in  1  cell value (1 = blocked or visited).
- mem_wr  out  1  write strobe; writes mem_wdata to mem_addr at the same edge.
- mem_wdata  out  1  always 1 when mem_wr=1 (visited mark).
- busy  out  1  high from start acceptance until DONE or FAIL.
- done  out  1  high in DONE, held until the next accepted start.
- fail  out  1  high in FAIL, held until the next accepted start.
- overflow  out  1  qualifies fail: 1 means the stack was full on a push.
- step_count  out  16  forward moves taken in the current solve; saturates at 16'hFFFF.
- path_valid  out  1  path stream valid.
- path_ready  in  1  path stream ready.
- path_loc  out  2*CW  path cell; the stream runs from start (0,0) to destination (all ones).
- path_last  out  1  marks the destination beat.

## Operation
- The start cell is location 0. The destination is location all-ones.
- Direction order: 0 = y+1, 1 = x+1, 2 = x-1, 3 = y-1.
- A neighbour outside 0..2^CW-1 on either axis is skipped with no memory access.
- The block never clears the maze RAM. The bench reloads the RAM before each solve.
- States:
  - IDLE: on start, cur=0, sp=0, step_count=0, overflow=0 -> MARK.
  - MARK: mem_wr=1, mem_addr=cur. If cur = all-ones -> PUSHD, else dir=0 -> CHECK.
  - CHECK: compute neighbour nb from cur+dir. Out of range -> NEXT; else mem_rd=1, mem_addr=nb -> EVAL.
  - EVAL: mem_rdata=1 -> NEXT. mem_rdata=0 -> if sp=STK_DEPTH then overflow=1 -> FAIL; else push cur, cur=nb, step_count+1 -> MARK.
  - NEXT: dir=3 -> BACK; else dir+1 -> CHECK.
  - BACK: sp=0 -> FAIL; else pop into cur, dir=0 -> CHECK. The cell is already marked, so no rewrite.
  - PUSHD: push the destination. If full, overflow=1 -> FAIL; else rd_ptr=0 -> PATH.
  - PATH: path_valid=1, path_loc=stack[rd_ptr], path_last=(rd_ptr=sp-1). On path_valid&path_ready, rd_ptr+1; on the last beat -> DONE.
  - DONE: done=1. start -> IDLE actions, then MARK.
  - FAIL: fail=1. start -> IDLE actions, then MARK.
- start in any other state is ignored.
- The stack is a register array, bottom to top. Pop returns the most recent push.
- Backtracking re-tries all directions from dir=0. Visited marks make this finite.

## Timing
- Reset (rst=0 at an edge): state IDLE. All outputs 0: busy, done, fail, overflow, mem_rd, mem_wr, mem_wdata, path_valid, path_last, mem_addr, path_loc, step_count.
- Reset mid-solve or mid-stream aborts immediately. No memory write is issued in the reset cycle.
- Cost per step:
  - Forward move: 3 cycles (MARK, CHECK, EVAL).
  - Skipped out-of-range direction: 2 cycles (CHECK, NEXT).
  - Blocked direction: 3 cycles (CHECK, EVAL, NEXT).
  - Backtrack: 1 cycle (BACK) plus the retry.
- Stream handshake:
  - path_loc and path_last are stable while path_valid=1 && path_ready=0.
  - One beat transfers per cycle with path_ready held high.
  - The cycle after the last beat, path_valid=0 and done=1.
- busy falls in the same cycle done or fail rises.
- A 1x1 maze is not supported; CW >= 1. The start cell is never read; it is marked in the first MARK.

## Test plan
- CW=2, all-free RAM, path_ready=1:
  - path_loc = 0,4,8,12,13,14,15, with path_last on 15.
  - done=1, step_count=6, every visited cell written to 1.
- CW=2, cells 4 and 1 walled:
  - FAIL after BACK with sp=0; fail=1, overflow=0, done=0, step_count=0.
- CW=2, column x=0 free, cell 13 walled, path via 9,10,14:
  - Path contains a backtrack from 12. Stream = 0,4,8,9,13? No: 13 is walled, so stream = 0,4,8,9,10,14,15.
  - The popped cell 12 is absent from the stream.
- CW=2, STK_DEPTH=4, all-free RAM:
  - fail=1, overflow=1 on the 5th push attempt. mem_wr count = 5.
- Path backpressure: toggle path_ready each cycle.
  - Each beat is held until accepted; the sequence is identical to test 1.
- Assert rst=0 during PATH, then pulse start after a RAM reload:
  - All outputs 0 after reset; the solve repeats the test 1 result.
